multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS-subset datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the ALU's 2-bit aluOp and the funct-source select, plus all datapath muxes and write enables. It updates state on the rising edge of clock; the ALU evaluates on the falling edge, so ALU inputs are stable for half a cycle and results are valid before the next rising edge.

Parameters:
CNT_W, 32, width of the retired-instruction counter
STATE_W, 4, width of the state register and state output

Ports:
clock  in  1  system clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
opcode  in  6  instruction register bits [31:26]
zero  in  1  ALU zero flag
mem_ready  in  1  memory handshake; the current memory access completes in a cycle where this is 1
alu_op  out  2  to ALU aluOp
alu_funct_sel  out  1  1: ALU funct input driven by opcode; 0: driven by IR[5:0]
alu_src_a  out  1  0: PC; 1: register A
alu_src_b  out  2  00: B; 01: constant 4; 10: sign-extended immediate; 11: sign-extended immediate shifted left 2
pc_source  out  2  00: ALU result; 01: ALUOut; 10: jump target
pc_en  out  1  PC write enable, equal to pc_write OR (pc_write_cond AND zero)
i_or_d  out  1  memory address: 0 PC; 1 ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR load
reg_dst  out  1  0: rt; 1: rd
mem_to_reg  out  1  0: ALUOut; 1: MDR
reg_write  out  1  register file write
illegal_op  out  1  one-cycle pulse on an undecodable opcode
state  out  STATE_W  current state, for debug
retired  out  CNT_W  count of completed instructions

Behaviour:
- Decoded opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, slti 001010, j 000010. Every other opcode is illegal.
- States and encodings: FETCH 0, DECODE 1, MEMADDR 2, MEMRD 3, MEMWB 4, MEMWR 5, REXEC 6, RWB 7, BRANCH 8, IEXEC 9, IWB 10, JUMP 11, TRAP 12.
- Outputs are Moore-decoded from state. Any output not listed for a state is 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_write equal mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes the branch target).
  - lw/sw go to MEMADDR; R to REXEC; beq/bne to BRANCH; addi/slti to IEXEC; j to JUMP; illegal to TRAP.
- MEMADDR: alu_src_a=1, alu_src_b=10, alu_op=00. lw goes to MEMRD; sw goes to MEMWR.
- MEMRD: mem_read=1, i_or_d=1. Stay while mem_ready=0, then go to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Next is FETCH.
- MEMWR: mem_write=1, i_or_d=1. Stay while mem_ready=0, then go to FETCH.
- REXEC: alu_src_a=1, alu_src_b=00, alu_op=10, alu_funct_sel=0. Next is RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next is FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, pc_source=01, pc_write_cond=1.
  - beq: alu_op=01, alu_funct_sel=0.
  - bne: alu_op=11, alu_funct_sel=1; the ALU raises zero when the operands differ.
  - pc_en takes the zero value that the ALU produces at the falling edge within BRANCH. Next is FETCH.
- IEXEC: alu_src_a=1, alu_src_b=10, alu_op=11, alu_funct_sel=1. Next is IWB.
- IWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next is FETCH.
- JUMP: pc_write=1, pc_source=10. Next is FETCH.
- TRAP: illegal_op=1 for exactly one cycle. Next is FETCH; retired is not incremented.
- retired increments by 1 on the rising edge that leaves MEMWB, MEMWR (with mem_ready=1), RWB, BRANCH, IWB or JUMP. It wraps to 0 at 2^CNT_W-1.
- Latency with mem_ready held at 1: R/addi/slti 4 cycles, lw 5, sw 4, beq/bne 3, j 3, illegal 3.
- Reset: state goes to FETCH and retired to 0.
  - While reset=1, ir_write, pc_en, mem_read, mem_write, reg_write and illegal_op are forced to 0, even mid-instruction. A partially executed instruction is abandoned with no write.
  - The first cycle after reset deasserts is a normal FETCH.
- Mid-access wait: while mem_ready=0, all outputs hold their values and the strobes stay asserted.
- opcode is sampled only in DECODE and MEMADDR; IR is stable in those states.

Test Plan:
- Reset held 3 cycles mid-REXEC, mem_ready=1 -> state=0, retired=0, no reg_write pulse; first post-reset cycle shows mem_read=1, ir_write=1, pc_en=1.
- opcode=000000, mem_ready=1 -> states 0,1,6,7,0; alu_op=10 in REXEC; reg_write=1 and reg_dst=1 in RWB only; retired goes 0->1.
- lw with mem_ready=0 for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; mem_read and i_or_d held at 1 throughout MEMRD; mem_to_reg=1 in MEMWB.
- beq with zero=1, then bne with zero=0 -> pc_en=1 in the first BRANCH (alu_op=01) and 0 in the second (alu_op=11, alu_funct_sel=1); each takes 3 cycles; retired +2.
- slti (001010) -> IEXEC drives alu_op=11, alu_funct_sel=1, alu_src_b=10; IWB has reg_dst=0, reg_write=1.
- opcode=111111 -> states 0,1,12,0; illegal_op high exactly 1 cycle; retired unchanged; no write enables asserted.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS-subset datapath.
// Each instruction is sequenced through fetch, decode, execute, memory and
// writeback states. Datapath controls are Moore-decoded from the current state.
// The exceptions are these inputs:
// - mem_ready gates ir_write and the PC write in FETCH.
// - zero combines with pc_write_cond to form pc_en.
// - reset forces every strobe low.
// The ALU evaluates on the falling edge, so zero is settled before the rising
// edge that consumes pc_en.
module multicycle_ctrl #(
  parameter int CNT_W   = 32,
  parameter int STATE_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic [1:0]         alu_op,
  output logic               alu_funct_sel,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic               pc_en,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   retired
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_REXEC   = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_IEXEC   = 4'd9,
    S_IWB     = 4'd10,
    S_JUMP    = 4'd11,
    S_TRAP    = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t           r_state;
  state_t           w_next;
  logic             r_is_bne;
  logic [CNT_W-1:0] r_retired;

  // Raw Moore controls before reset gating.
  logic [1:0] w_alu_op;
  logic       w_alu_funct_sel;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_pc_source;
  logic       w_pc_write;
  logic       w_pc_write_cond;
  logic       w_i_or_d;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_dst;
  logic       w_mem_to_reg;
  logic       w_reg_write;
  logic       w_illegal;
  logic       w_retire;

  // Dispatch target out of DECODE; anything not in the subset traps.
  function automatic state_t f_dispatch(input logic [5:0] op);
    state_t s;
    case (op)
      OP_LW, OP_SW:     s = S_MEMADDR;
      OP_R:             s = S_REXEC;
      OP_BEQ, OP_BNE:   s = S_BRANCH;
      OP_ADDI, OP_SLTI: s = S_IEXEC;
      OP_J:             s = S_JUMP;
      default:          s = S_TRAP;
    endcase
    return s;
  endfunction

  // State register; reset abandons any in-flight instruction.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Remember beq/bne at decode so BRANCH never depends on opcode.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_is_bne <= 1'b0;
    end else if (r_state == S_DECODE) begin
      r_is_bne <= (opcode == OP_BNE);
    end
  end

  // Retired-instruction counter; wraps naturally at its width.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  // Next-state and Moore output decode; every output defaults to 0.
  always_comb begin
    w_next          = r_state;
    w_alu_op        = 2'b00;
    w_alu_funct_sel = 1'b0;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = 2'b00;
    w_pc_source     = 2'b00;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_i_or_d        = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_reg_dst       = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_reg_write     = 1'b0;
    w_illegal       = 1'b0;
    w_retire        = 1'b0;
    case (r_state)
      S_FETCH: begin
        // PC + 4 is computed alongside the instruction read.
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'b01;
        w_ir_write  = mem_ready;
        w_pc_write  = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        // Branch target precomputed while the register file is read.
        w_alu_src_b = 2'b11;
        w_next      = f_dispatch(opcode);
      end
      S_MEMADDR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        if (opcode == OP_LW) begin
          w_next = S_MEMRD;
        end else if (opcode == OP_SW) begin
          w_next = S_MEMWR;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_MEMRD: begin
        w_mem_read = 1'b1;
        w_i_or_d   = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_retire     = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWR: begin
        w_mem_write = 1'b1;
        w_i_or_d    = 1'b1;
        if (mem_ready) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_REXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b10;
        w_next      = S_RWB;
      end
      S_RWB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        // For bne the ALU is asked to raise zero when operands differ.
        w_alu_src_a     = 1'b1;
        w_pc_source     = 2'b01;
        w_pc_write_cond = 1'b1;
        w_alu_op        = r_is_bne ? 2'b11 : 2'b01;
        w_alu_funct_sel = r_is_bne;
        w_retire        = 1'b1;
        w_next          = S_FETCH;
      end
      S_IEXEC: begin
        w_alu_src_a     = 1'b1;
        w_alu_src_b     = 2'b10;
        w_alu_op        = 2'b11;
        w_alu_funct_sel = 1'b1;
        w_next          = S_IWB;
      end
      S_IWB: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        w_pc_write  = 1'b1;
        w_pc_source = 2'b10;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
      S_TRAP: begin
        w_illegal = 1'b1;
        w_next    = S_FETCH;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Mux selects pass straight through; strobes are held off during reset.
  assign alu_op        = w_alu_op;
  assign alu_funct_sel = w_alu_funct_sel;
  assign alu_src_a     = w_alu_src_a;
  assign alu_src_b     = w_alu_src_b;
  assign pc_source     = w_pc_source;
  assign i_or_d        = w_i_or_d;
  assign reg_dst       = w_reg_dst;
  assign mem_to_reg    = w_mem_to_reg;
  assign pc_en         = (w_pc_write | (w_pc_write_cond & zero)) & ~reset;
  assign mem_read      = w_mem_read  & ~reset;
  assign mem_write     = w_mem_write & ~reset;
  assign ir_write      = w_ir_write  & ~reset;
  assign reg_write     = w_reg_write & ~reset;
  assign illegal_op    = w_illegal   & ~reset;
  assign state         = STATE_W'(r_state);
  assign retired       = r_retired;

endmodule
